uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single transmit path of the `uart` block (its `wr_uart` / `w_data` / `tx_full` write port into the TX FIFO) among NREQ independent requesters. A granted requester sends a burst of 32-bit words. The arbiter first writes a header word identifying the requester and burst length, then streams the payload words, throttled by `tx_full`. It sits between the client logic and the `uart` instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester index, equals ceil(log2(NREQ))
- LENW, 8, width of burst length field (max 16)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset; one clock domain
- req  in  NREQ  per-requester burst request; sampled only in IDLE
- req_len  in  NREQ*LENW  burst payload length, requester i at bits [i*LENW +: LENW]; sampled at grant
- req_data  in  NREQ*32  current payload word, requester i at bits [i*32 +: 32]
- req_ack  out  NREQ  one-hot pulse: granted requester's current word was written; requester advances to next word
- req_done  out  NREQ  one-hot, one-cycle pulse when the requester's burst is fully written
- tx_full  in  1  TX FIFO full, from `uart`
- wr_uart  out  1  TX FIFO write strobe, to `uart`
- w_data  out  32  TX FIFO write data, to `uart`
- busy  out  1  high in HDR or DATA
- cur_id  out  IDW  index of the granted requester; valid while busy

## Operation
- States: IDLE, HDR, DATA.
- IDLE:
  - If any req bit is set, grant the first set bit at or after `rr_ptr`, searching cyclically upward with wrap from NREQ-1 to 0.
  - On grant, register `cur_id` and latch `cnt` = req_len[cur_id]; go to HDR.
  - If no req bit is set, stay in IDLE.
- HDR:
  - wr_uart = ~tx_full.
  - w_data = {8'hA5, 8'(cur_id), 16'(len)}, with id and len zero-extended.
  - On a write: if cnt == 0, pulse req_done[cur_id] and go to IDLE; otherwise go to DATA.
- DATA:
  - wr_uart = ~tx_full and w_data = req_data[cur_id].
  - req_ack[cur_id] = wr_uart.
  - On each write, cnt decrements. The write with cnt == 1 also pulses req_done[cur_id], and the next state is IDLE.
- `rr_ptr`:
  - On every burst completion, rr_ptr = cur_id+1, wrapping mod NREQ.
  - Reset value is 0, so requester 0 has top priority first.
- Requester deasserting req mid-burst:
  - This does not abort the burst; all latched len words are written using whatever req_data presents.
  - Requesters must hold req_data stable until req_ack.
- req bits for other requesters are ignored while busy, with no preemption.
- wr_uart, w_data and req_ack are combinational from the state and tx_full. While wr_uart is 0, w_data is don't-care.
- Reset asserted mid-burst: immediately returns to IDLE with all outputs at their reset values. The partial burst is lost; no req_done is issued.

## Timing
- Reset values: state=IDLE, rr_ptr=0, cnt=0, cur_id=0, busy=0, wr_uart=0, req_ack=0, req_done=0, w_data=0.
- Grant latency: req rises in cycle t while IDLE → HDR in t+1 → header written in t+1 if tx_full=0.
- Throughput with tx_full=0:
  - A burst of len L occupies L+1 consecutive write cycles.
  - One IDLE cycle separates bursts, so back-to-back bursts take L+2 cycles each.
- tx_full=1 in HDR/DATA: no write, no ack and no counter change; the state holds with no limit.
- req_done coincides with the final wr_uart cycle, and busy drops the following cycle.
- req sampled in the same cycle busy falls: not seen. Arbitration occurs in the IDLE cycle.

## Test plan
- Single request, no backpressure: req=0001, len=3, data words 0x11,0x22,0x33 → writes 0xA5000003, 0x11, 0x22, 0x33 on 4 consecutive cycles; req_ack[0] on the last 3; req_done[0] with 0x33.
- Round-robin fairness: req=1111 held, each len=1, starting from reset → grant order 0,1,2,3,0; each header id field is correct.
- Backpressure: tx_full high for 5 cycles mid-DATA → no wr_uart or req_ack during those cycles; the word stays stable and is written the cycle tx_full falls; total writes remain len+1.
- Zero length: req=0100, len=0 → single write 0xA5020000, req_done[2] the same cycle, and rr_ptr advances to 3.
- Reset mid-burst: assert reset after 2 of 5 payload words → wr_uart=0 and busy=0 immediately, no req_done; after release, req=0010 is granted with rr_ptr=0 ordering.
- Wrap priority: last granted 3, req=1001 → requester 0 is granted next.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the uart TX FIFO write port.
// master: the arbiter's view; slave: the requesters' and uart's view.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int LENW = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_done;
    logic                 tx_full;
    logic                 wr_uart;
    logic [31:0]          w_data;

    modport master (
        input  req, req_len, req_data, tx_full,
        output req_ack, req_done, wr_uart, w_data
    );

    modport slave (
        output req, req_len, req_data, tx_full,
        input  req_ack, req_done, wr_uart, w_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing the uart TX FIFO write port among NREQ
// requesters. Each grant emits a header word {A5, id, len} followed by
// len payload words, all throttled by tx_full.
module uart_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int LENW = 8
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_arbiter_if.master   bus,
    output logic                busy,
    output logic [IDW-1:0]      cur_id
);

    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LENW-1:0] cnt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_next;

    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [LENW-1:0] len_sel;
    logic [31:0]     data_sel;
    logic [NREQ-1:0] cur_onehot;
    logic [31:0]     hdr_word;

    logic            wr;
    logic [31:0]     wdata;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] done;

    // Cyclic search from rr_ptr: first pass takes set bits at/after the
    // pointer, second pass falls back to the lowest set bit (wrap-around).
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (!grant_any && bus.req[i] && (i >= 32'(rr_ptr))) begin
                grant_any = 1'b1;
                grant_id  = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NR; i++) begin
            if (!grant_any && bus.req[i]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(i);
            end
        end
    end

    // Per-requester field selection: length of the candidate, payload and
    // one-hot of the granted requester.
    always_comb begin
        len_sel    = '0;
        data_sel   = '0;
        cur_onehot = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (grant_id == IDW'(i)) begin
                len_sel = bus.req_len[i*LENW +: LENW];
            end
            if (cur_id == IDW'(i)) begin
                data_sel      = bus.req_data[i*32 +: 32];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    assign hdr_word = {8'hA5, 8'(cur_id), 16'(cnt)};
    assign ptr_next = (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and write-port outputs; everything is a function of state and tx_full.
    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        wdata     = '0;
        ack       = '0;
        done      = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                wr    = ~bus.tx_full;
                wdata = hdr_word;
                if (wr) begin
                    if (cnt == '0) begin
                        done      = cur_onehot;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                wr    = ~bus.tx_full;
                wdata = data_sel;
                if (wr) begin
                    ack = cur_onehot;
                    if (cnt == LENW'(1)) begin
                        done      = cur_onehot;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant capture, payload countdown and round-robin pointer advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_id <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                cur_id <= grant_id;
                cnt    <= len_sel;
            end else if (state == DATA && wr) begin
                cnt <= cnt - 1'b1;
            end
            if (|done) begin
                rr_ptr <= ptr_next;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign bus.wr_uart  = wr;
    assign bus.w_data   = wdata;
    assign bus.req_ack  = ack;
    assign bus.req_done = done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a burst-level
// reference model (current requester, burst length, words written so far).
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LENW = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [IDW-1:0]   cur_id;

    uart_tx_arbiter_if #(.NREQ(NREQ), .LENW(LENW)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .LENW(LENW)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .cur_id (cur_id)
    );

    always #5 clk = ~clk;

    // stimulus state owned by the driver
    logic [NREQ-1:0] req_v = '0;
    logic [LENW-1:0] len_v [NREQ];
    logic [31:0]     pres  [NREQ];
    logic            full_v = 1'b0;
    logic [31:0]     data_q [NREQ][$];

    // Present driver variables on the interface.
    always_comb begin
        bus.req     = req_v;
        bus.tx_full = full_v;
        bus.req_len = '0;
        bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_len[i*LENW +: LENW] = len_v[i];
            bus.req_data[i*32 +: 32]    = pres[i];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: burst-level view
    int              m_busy = 0;
    int              m_id = 0;
    int              m_len = 0;
    int              m_pos = 0;
    int              m_ptr = 0;
    logic [NREQ-1:0] adv = '0;
    int              cyc = 0;

    typedef struct {
        int              cyc;
        logic [31:0]     data;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] done;
    } wr_t;
    wr_t obs[$];

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        logic            e_wr;
        logic [31:0]     e_data;
        logic [NREQ-1:0] e_ack;
        logic [NREQ-1:0] e_done;
        cyc++;
        if (!rst_n) begin
            m_busy = 0;
            m_ptr  = 0;
            adv    = '0;
            chk("rst_wr_uart", 32'(bus.wr_uart), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_req_ack", 32'(bus.req_ack), 32'd0);
            chk("rst_req_done", 32'(bus.req_done), 32'd0);
            chk("rst_w_data", bus.w_data, 32'd0);
            chk("rst_cur_id", 32'(cur_id), 32'd0);
        end else begin
            e_wr   = 1'b0;
            e_data = '0;
            e_ack  = '0;
            e_done = '0;
            if (m_busy != 0) begin
                e_wr   = !full_v;
                e_data = (m_pos == 0) ? {8'hA5, 8'(m_id), 16'(m_len)} : pres[m_id];
                if (e_wr && m_pos > 0) e_ack[m_id] = 1'b1;
                if (e_wr && m_pos == m_len) e_done[m_id] = 1'b1;
            end
            chk("wr_uart", 32'(bus.wr_uart), 32'(e_wr));
            chk("busy", 32'(busy), 32'(m_busy != 0));
            chk("req_ack", 32'(bus.req_ack), 32'(e_ack));
            chk("req_done", 32'(bus.req_done), 32'(e_done));
            if (e_wr) chk("w_data", bus.w_data, e_data);
            if (m_busy != 0) chk("cur_id", 32'(cur_id), 32'(m_id));
            if (bus.wr_uart === 1'b1)
                obs.push_back('{cyc: cyc, data: bus.w_data, ack: bus.req_ack, done: bus.req_done});
            adv = e_ack;
            if (m_busy == 0) begin
                if (req_v != '0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (m_busy == 0 && req_v[(m_ptr + k) % NREQ]) begin
                            m_busy = 1;
                            m_id   = (m_ptr + k) % NREQ;
                        end
                    end
                    m_len = int'(len_v[m_id]);
                    m_pos = 0;
                end
            end else if (e_wr) begin
                if (m_pos == m_len) begin
                    m_busy = 0;
                    m_ptr  = (m_id + 1) % NREQ;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    // one clock step; acknowledged requesters move to their next word
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (adv[i]) begin
                if (data_q[i].size() > 0) pres[i] = data_q[i].pop_front();
                else pres[i] = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_v  = '0;
        full_v = 1'b0;
        for (int i = 0; i < NREQ; i++) data_q[i].delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while (busy === 1'b1 && c < maxc) begin
            tick();
            c++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_writes(input int n, input int maxc);
        int c;
        c = 0;
        while (obs.size() < n && c < maxc) begin
            tick();
            c++;
        end
        chk("writes_reached", 32'(obs.size() >= n), 32'd1);
    endtask

    function automatic logic [31:0] od(input int k);
        if (k < obs.size()) return obs[k].data;
        return 'x;
    endfunction
    function automatic int oc(input int k);
        if (k < obs.size()) return obs[k].cyc;
        return -1000;
    endfunction
    function automatic logic [NREQ-1:0] oa(input int k);
        if (k < obs.size()) return obs[k].ack;
        return 'x;
    endfunction
    function automatic logic [NREQ-1:0] odn(input int k);
        if (k < obs.size()) return obs[k].done;
        return 'x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ndone;
        for (int i = 0; i < NREQ; i++) begin
            len_v[i] = '0;
            pres[i]  = '0;
        end

        // single burst, no backpressure
        do_reset();
        obs.delete();
        pres[0] = 32'h11;
        data_q[0].push_back(32'h22);
        data_q[0].push_back(32'h33);
        len_v[0] = 8'd3;
        req_v = 4'b0001;
        tick();
        req_v = '0;
        wait_idle(20);
        chk("t1_nwr", 32'(obs.size()), 32'd4);
        chk("t1_hdr", od(0), 32'hA500_0003);
        chk("t1_w1", od(1), 32'h11);
        chk("t1_w2", od(2), 32'h22);
        chk("t1_w3", od(3), 32'h33);
        chk("t1_span", 32'(oc(3) - oc(0)), 32'd3);
        chk("t1_ack0", 32'(oa(0)), 32'd0);
        chk("t1_ack3", 32'(oa(3)), 32'b0001);
        chk("t1_done3", 32'(odn(3)), 32'b0001);

        // round-robin fairness from reset
        do_reset();
        obs.delete();
        for (int i = 0; i < NREQ; i++) len_v[i] = 8'd1;
        req_v = 4'b1111;
        wait_writes(10, 60);
        req_v = '0;
        wait_idle(20);
        chk("rr_hdr0", od(0), 32'hA500_0001);
        chk("rr_hdr1", od(2), 32'hA501_0001);
        chk("rr_hdr2", od(4), 32'hA502_0001);
        chk("rr_hdr3", od(6), 32'hA503_0001);
        chk("rr_hdr4", od(8), 32'hA500_0001);
        chk("rr_period", 32'(oc(2) - oc(0)), 32'd3);

        // backpressure mid-DATA
        do_reset();
        obs.delete();
        len_v[0] = 8'd4;
        pres[0] = 32'hA1;
        data_q[0].push_back(32'hA2);
        data_q[0].push_back(32'hA3);
        data_q[0].push_back(32'hA4);
        req_v = 4'b0001;
        tick();
        req_v = '0;
        repeat (3) tick();
        full_v = 1'b1;
        repeat (5) tick();
        full_v = 1'b0;
        wait_idle(20);
        chk("bp_nwr", 32'(obs.size()), 32'd5);
        chk("bp_hdr", od(0), 32'hA500_0004);
        chk("bp_w2", od(2), 32'hA2);
        chk("bp_w3", od(3), 32'hA3);
        chk("bp_gap", 32'(oc(3) - oc(2)), 32'd6);
        chk("bp_done", 32'(odn(4)), 32'b0001);

        // zero length, pointer advance and wrap priority
        do_reset();
        obs.delete();
        len_v[2] = 8'd0;
        req_v = 4'b0100;
        tick();
        req_v = '0;
        wait_idle(20);
        chk("z_nwr", 32'(obs.size()), 32'd1);
        chk("z_hdr", od(0), 32'hA502_0000);
        chk("z_done", 32'(odn(0)), 32'b0100);
        len_v[0] = 8'd0;
        len_v[3] = 8'd0;
        req_v = 4'b1001;
        wait_writes(3, 40);
        req_v = '0;
        wait_idle(20);
        chk("z_ptr3", od(1), 32'hA503_0000);
        chk("z_wrap0", od(2), 32'hA500_0000);

        // reset mid-burst (pointer first moved to 3)
        do_reset();
        obs.delete();
        len_v[2] = 8'd0;
        req_v = 4'b0100;
        tick();
        req_v = '0;
        wait_idle(20);
        len_v[0] = 8'd5;
        req_v = 4'b0001;
        tick();
        req_v = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mr_wr_uart", 32'(bus.wr_uart), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(bus.req_done), 32'd0);
        ndone = 0;
        foreach (obs[k]) if (obs[k].done[0]) ndone++;
        chk("mr_no_done", 32'(ndone), 32'd0);
        chk("mr_partial", 32'(obs.size()), 32'd4);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        obs.delete();
        len_v[1] = 8'd2;
        len_v[3] = 8'd2;
        req_v = 4'b1010;
        tick();
        req_v = '0;
        wait_idle(20);
        chk("mr_regrant", od(0), 32'hA501_0002);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req_v = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) len_v[i] = LENW'($urandom_range(0, 16));
            full_v = ($urandom_range(0, 99) < 25);
            if (n == 1500) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        req_v  = '0;
        full_v = 1'b0;
        wait_idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
